// File: rtl/alu_op_engine_if.sv
// Request/response bundle for alu_op_engine: operand request handshake in,
// registered result handshake out.
interface alu_op_engine_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ans;
  logic             carry;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, ans, carry, zero, err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, ans, carry, zero, err
  );
endinterface

// File: rtl/alu_op_engine.sv
// Unsigned eight-op ALU with an iterative shift-add multiplier, fronted by a
// valid/ready request port and holding its result behind a valid/ready port.
module alu_op_engine #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  alu_op_engine_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [3:0]             r_op;
  logic [2*WIDTH-1:0]     r_acc;
  logic [SHW-1:0]         r_cnt;
  logic [WIDTH-1:0]       r_ans;
  logic                   r_carry;
  logic                   r_zero;
  logic                   r_err;
  logic                   r_out_valid;

  logic                   w_accept;
  logic                   w_consume;
  logic                   w_is_mul;
  logic                   w_mul_last;
  logic                   w_exec_done;
  logic [WIDTH:0]         w_step_sum;
  logic [2*WIDTH-1:0]     w_acc_next;
  logic [WIDTH:0]         w_alu;
  logic [WIDTH-1:0]       w_res_ans;
  logic                   w_res_carry;
  logic                   w_res_err;

  // Single-step ops; bit WIDTH is the carry/borrow. Mul and illegal return 0.
  function automatic logic [WIDTH:0] alu_eval(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic [3:0]       code);
    logic [WIDTH:0] r;
    r = '0;
    case (code)
      4'd0: r = {1'b0, x} + {1'b0, y};
      4'd1: r = {(x < y), x - y};
      4'd3: r = {1'b0, x & y};
      4'd4: r = {1'b0, x | y};
      4'd5: r = {1'b0, x ^ y};
      4'd6: r = {1'b0, x << y[SHW-1:0]};
      4'd7: r = {1'b0, x >> y[SHW-1:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic op_legal(input logic [3:0] code);
    return (code[3] == 1'b0);
  endfunction

  assign w_is_mul   = (r_op == 4'd2);
  assign w_mul_last = (r_cnt == SHW'(WIDTH - 1));

  // One shift-add step: r_b is shifted right each step so bit 0 is the current multiplier bit.
  assign w_step_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
  assign w_acc_next = (2*WIDTH)'({w_step_sum, r_acc[WIDTH-1:0]} >> 1);
  assign w_alu      = alu_eval(r_a, r_b, r_op);

  always_comb begin
    w_res_ans   = '0;
    w_res_carry = 1'b0;
    w_res_err   = 1'b0;
    if (w_is_mul) begin
      w_res_ans   = w_acc_next[WIDTH-1:0];
      w_res_carry = |w_acc_next[2*WIDTH-1:WIDTH];
    end else if (op_legal(r_op)) begin
      w_res_ans   = w_alu[WIDTH-1:0];
      w_res_carry = w_alu[WIDTH];
    end else begin
      w_res_err   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_next = S_EXEC;
      S_EXEC:  if (w_exec_done) w_next = S_DONE;
      S_DONE:  if (w_consume)   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (r_state == S_IDLE);
    w_accept     = (r_state == S_IDLE) && bus.in_valid;
    w_consume    = (r_state == S_DONE) && r_out_valid && bus.out_ready;
    w_exec_done  = (r_state == S_EXEC) && (!w_is_mul || w_mul_last);
  end

  // Operand capture, multiply iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ans       <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_op  <= bus.op;
        r_acc <= '0;
        r_cnt <= '0;
      end
      if (r_state == S_EXEC && w_is_mul) begin
        r_acc <= w_acc_next;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt + SHW'(1);
      end
      if (w_exec_done) begin
        r_ans       <= w_res_ans;
        r_carry     <= w_res_carry;
        r_zero      <= (w_res_ans == '0);
        r_err       <= w_res_err;
        r_out_valid <= 1'b1;
      end
      if (w_consume) begin
        r_out_valid <= 1'b0;
        r_err       <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.ans       = r_ans;
  assign bus.carry     = r_carry;
  assign bus.zero      = r_zero;
  assign bus.err       = r_err;

endmodule
